set_button_ctrl: RTL and testbench



---
 rtl/set_button_ctrl_pkg.sv | 21 ++
 rtl/set_rate_sel.sv | 44 ++++
 rtl/set_button_ctrl.sv | 119 +++++++++++
 tb/tb_set_button_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/set_button_ctrl_pkg.sv
// Shared types and defaults for the set-button controller: FSM states,
// button-select encoding and default timing parameters.
package set_button_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    HOLD_WAIT,
    REPEAT,
    LOCK
  } state_t;

  typedef enum logic {
    SEL_HOURS   = 1'b0,
    SEL_MINUTES = 1'b1
  } sel_t;

  localparam int HOLD_DELAY_DEF  = 3;
  localparam int ACCEL_COUNT_DEF = 8;

endpackage

// File: rtl/set_rate_sel.sv
// Repeat-rate strobe selection for the set-button controller.
// Optional acceleration (macro SET_BUTTON_ACCEL_EN) forces the fast rate after ACCEL_COUNT slow repeats.
module set_rate_sel
  import set_button_ctrl_pkg::*;
#(
  parameter int ACCEL_COUNT = ACCEL_COUNT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_active,
  input  logic i_emit,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_fast_set_db,
  output logic o_rate_stb
);

`ifdef SET_BUTTON_ACCEL_EN
  localparam logic [7:0] ACCEL_MAX = 8'(ACCEL_COUNT);

  logic [7:0] r_repCnt;
  logic       w_useFast;

  assign w_useFast  = i_fast_set_db || (r_repCnt == ACCEL_MAX);
  assign o_rate_stb = w_useFast ? i_fast_set_stb : i_slow_set_stb;

  // Only increments emitted at the slow rate count toward acceleration.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_repCnt <= '0;
    end else if (!i_active) begin
      r_repCnt <= '0;
    end else if (i_emit && !w_useFast && (r_repCnt != ACCEL_MAX)) begin
      r_repCnt <= r_repCnt + 8'd1;
    end
  end
`else
  logic w_unused;

  assign w_unused   = &{1'b0, i_clk, i_reset, i_active, i_emit, 8'(ACCEL_COUNT)};
  assign o_rate_stb = i_fast_set_db ? i_fast_set_stb : i_slow_set_stb;
`endif

endmodule

// File: rtl/set_button_ctrl.sv
// Turns debounced set-hours/set-minutes levels into single-cycle increment
// strobes with hold-to-repeat; optional acceleration via SET_BUTTON_ACCEL_EN.
module set_button_ctrl
  import set_button_ctrl_pkg::*;
#(
  parameter int HOLD_DELAY  = HOLD_DELAY_DEF,
  parameter int ACCEL_COUNT = ACCEL_COUNT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_slow_set_stb,
  input  logic i_fast_set_stb,
  input  logic i_set_hours_db,
  input  logic i_set_minutes_db,
  input  logic i_fast_set_db,
  output logic o_inc_hours_stb,
  output logic o_inc_minutes_stb,
  output logic o_hold_time
);

  localparam logic [3:0] HOLD_MAX = 4'(HOLD_DELAY);

  state_t     r_state;
  state_t     w_stateNext;
  sel_t       r_sel;
  sel_t       w_selNext;
  logic [3:0] r_holdCnt;
  logic [3:0] w_holdCntNext;
  logic       w_selHeld;
  logic       w_otherHeld;
  logic       w_inRepeat;
  logic       w_rateStb;
  logic       w_inc;

  assign w_selHeld   = (r_sel == SEL_HOURS) ? i_set_hours_db : i_set_minutes_db;
  assign w_otherHeld = (r_sel == SEL_HOURS) ? i_set_minutes_db : i_set_hours_db;
  assign w_inRepeat  = (r_state == REPEAT);

  set_rate_sel #(
    .ACCEL_COUNT(ACCEL_COUNT)
  ) u_rate_sel (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_active      (w_inRepeat),
    .i_emit        (w_inc),
    .i_slow_set_stb(i_slow_set_stb),
    .i_fast_set_stb(i_fast_set_stb),
    .i_fast_set_db (i_fast_set_db),
    .o_rate_stb    (w_rateStb)
  );

  // A second button or a release always wins over any pending strobe.
  always_comb begin
    w_stateNext   = r_state;
    w_selNext     = r_sel;
    w_holdCntNext = r_holdCnt;
    w_inc         = 1'b0;
    case (r_state)
      IDLE: begin
        w_holdCntNext = '0;
        if (i_set_hours_db && i_set_minutes_db) begin
          w_stateNext = LOCK;
        end else if (i_set_hours_db) begin
          w_stateNext = FIRST;
          w_selNext   = SEL_HOURS;
          w_inc       = 1'b1;
        end else if (i_set_minutes_db) begin
          w_stateNext = FIRST;
          w_selNext   = SEL_MINUTES;
          w_inc       = 1'b1;
        end
      end
      FIRST: begin
        w_holdCntNext = '0;
        if (w_otherHeld)     w_stateNext = LOCK;
        else if (!w_selHeld) w_stateNext = IDLE;
        else                 w_stateNext = HOLD_WAIT;
      end
      HOLD_WAIT: begin
        if (w_otherHeld) begin
          w_stateNext = LOCK;
        end else if (!w_selHeld) begin
          w_stateNext = IDLE;
        end else if (i_slow_set_stb) begin
          if (r_holdCnt != HOLD_MAX) w_holdCntNext = r_holdCnt + 4'd1;
          if (w_holdCntNext == HOLD_MAX) w_stateNext = REPEAT;
        end
      end
      REPEAT: begin
        if (w_otherHeld)     w_stateNext = LOCK;
        else if (!w_selHeld) w_stateNext = IDLE;
        else                 w_inc = w_rateStb;
      end
      LOCK: begin
        if (!i_set_hours_db && !i_set_minutes_db) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= IDLE;
      r_sel             <= SEL_HOURS;
      r_holdCnt         <= '0;
      o_inc_hours_stb   <= 1'b0;
      o_inc_minutes_stb <= 1'b0;
      o_hold_time       <= 1'b0;
    end else begin
      r_state           <= w_stateNext;
      r_sel             <= w_selNext;
      r_holdCnt         <= w_holdCntNext;
      o_inc_hours_stb   <= w_inc && (w_selNext == SEL_HOURS);
      o_inc_minutes_stb <= w_inc && (w_selNext == SEL_MINUTES);
      o_hold_time       <= (w_stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_set_button_ctrl.sv
// Scoreboard bench for set_button_ctrl: stimulus pushes expected strobe
// events, a negedge monitor pops and compares them as the DUT emits strobes.
module tb_set_button_ctrl;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_slow_set_stb;
  logic i_fast_set_stb;
  logic i_set_hours_db;
  logic i_set_minutes_db;
  logic i_fast_set_db;
  logic o_inc_hours_stb;
  logic o_inc_minutes_stb;
  logic o_hold_time;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    logic isHours;
  } expEvent_t;

  expEvent_t expQ[$];

  set_button_ctrl dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_slow_set_stb   (i_slow_set_stb),
    .i_fast_set_stb   (i_fast_set_stb),
    .i_set_hours_db   (i_set_hours_db),
    .i_set_minutes_db (i_set_minutes_db),
    .i_fast_set_db    (i_fast_set_db),
    .o_inc_hours_stb  (o_inc_hours_stb),
    .o_inc_minutes_stb(o_inc_minutes_stb),
    .o_hold_time      (o_hold_time)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Every strobe the DUT presents must match the oldest expected event.
  always @(negedge i_clk) begin
    expEvent_t e;
    if (o_inc_hours_stb && o_inc_minutes_stb) begin
      checks++;
      errors++;
      $display("[TB] FAIL both_strobes: cycle %0d got hours=1 minutes=1 expected at most one", cyc);
    end else if (o_inc_hours_stb || o_inc_minutes_stb) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe: cycle %0d got hours=%b minutes=%b expected none",
                 cyc, o_inc_hours_stb, o_inc_minutes_stb);
      end else begin
        e = expQ.pop_front();
        if (e.cyc != cyc || e.isHours != o_inc_hours_stb) begin
          errors++;
          $display("[TB] FAIL strobe_event: got cycle %0d hours=%b expected cycle %0d hours=%b",
                   cyc, o_inc_hours_stb, e.cyc, e.isHours);
        end
      end
    end
  end

  task automatic applyStimulus(input logic h, input logic m, input logic f,
                               input logic slow, input logic fast);
    i_set_hours_db   = h;
    i_set_minutes_db = m;
    i_fast_set_db    = f;
    i_slow_set_stb   = slow;
    i_fast_set_stb   = fast;
    @(negedge i_clk);
  endtask

  task automatic expectStb(input logic isHours);
    expQ.push_back('{cyc + 1, isHours});
  endtask

  task automatic checkOutput(input string name, input logic expHold,
                             input logic expH, input logic expM);
    checks++;
    if ({o_hold_time, o_inc_hours_stb, o_inc_minutes_stb} !== {expHold, expH, expM}) begin
      errors++;
      $display("[TB] FAIL %s: got hold/hrs/min=%b%b%b expected %b%b%b", name,
               o_hold_time, o_inc_hours_stb, o_inc_minutes_stb, expHold, expH, expM);
    end
  endtask

  // Press one button and walk it through FIRST and HOLD_WAIT into REPEAT.
  task automatic pressToRepeat(input logic isHours);
    expectStb(isHours);
    applyStimulus(isHours, !isHours, 1'b0, 1'b0, 1'b0);
    applyStimulus(isHours, !isHours, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(isHours, !isHours, 1'b0, 1'b1, 1'b0);
      applyStimulus(isHours, !isHours, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    expEvent_t e;
    i_reset          = 1'b1;
    i_slow_set_stb   = 1'b0;
    i_fast_set_stb   = 1'b0;
    i_set_hours_db   = 1'b0;
    i_set_minutes_db = 1'b0;
    i_fast_set_db    = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] single hours press");
    expectStb(1'b1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("hours_first", 1'b1, 1'b1, 1'b0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("hours_hold_wait", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hours_release", 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] minutes held through 3+5 slow strobes");
    pressToRepeat(1'b0);
    checkOutput("minutes_enter_repeat", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expectStb(1'b0);
      applyStimulus(0, 1, 0, 1, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("minutes_release", 1'b0, 1'b0, 1'b0);

    $display("[TB] hours repeat with fast-set toggling");
    pressToRepeat(1'b1);
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("fast_ignores_slow", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expectStb(1'b1);
      applyStimulus(1, 0, 1, 0, 1);
      applyStimulus(1, 0, 1, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 1);
    expectStb(1'b1);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("release_with_strobe", 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("fast_alone_idle", 1'b0, 1'b0, 1'b0);

    $display("[TB] second button lockout");
    expectStb(1'b1);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("lock_entered", 1'b1, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("lock_one_held", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lock_released", 1'b0, 1'b0, 1'b0);
    expectStb(1'b0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("minutes_after_lock", 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("both_from_idle", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("both_released", 1'b0, 1'b0, 1'b0);

    $display("[TB] reset during repeat");
    pressToRepeat(1'b1);
    expectStb(1'b1);
    applyStimulus(1, 0, 0, 1, 0);
    #1 i_reset = 1'b1;
    #1 checkOutput("reset_async", 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("reset_held", 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;
    expectStb(1'b1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("after_reset_first", 1'b1, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);

`ifdef SET_BUTTON_ACCEL_EN
    $display("[TB] acceleration after 8 slow repeats");
    pressToRepeat(1'b1);
    for (int i = 0; i < 8; i++) begin
      expectStb(1'b1);
      applyStimulus(1, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 1, 0);
      expectStb(1'b1);
      applyStimulus(1, 0, 0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    pressToRepeat(1'b1);
    applyStimulus(1, 0, 0, 0, 1);
    expectStb(1'b1);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missed_strobe: got no strobe expected cycle %0d hours=%b", e.cyc, e.isHours);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
